axil_req_sched: RTL

Round-robin scheduler that shares one AXI4-Lite master port between `N_REQ` internal requesters. Each requester issues single-word read or write commands on a simple valid/ready port. The block serialises the commands onto the AXI4-Lite bus that feeds the `registers` slave, one transaction in flight at a time. It returns the read data, the response code and the measured bus latency to the requester that issued the command.

---
 rtl/axil_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/axil_req_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axil_sched_pkg.sv
// Shared types and constants for the AXI4-Lite request scheduler.
package axil_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } sched_state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_EXOKAY = 2'b01;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  localparam logic [3:0]  WSTRB_ALL   = 4'hF;
  localparam logic [15:0] LAT_MAX     = 16'hFFFF;

  function automatic logic [15:0] lat_inc(input logic [15:0] v);
    return (v == LAT_MAX) ? LAT_MAX : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    logic             found;
    int unsigned      j;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    idx       = '0;
    for (int unsigned i = 0; i < 32'(N); i++) begin
      j   = (32'(ptr) + i) % 32'(N);
      idx = IDX_W'(j);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axil_req_sched.sv
// Shares one AXI4-Lite master between N_REQ requesters, one transaction in flight.
module axil_req_sched
  import axil_sched_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [15:0]             rsp_latency,
  output logic [ADDR_W-1:0]       m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_W-1:0]       m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_W-1:0]       m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, arb_idx;
  logic [N_REQ-1:0]  arb_grant, gnt_q, req_ready_q;
  logic [ADDR_W-1:0] addr_q, addr_sel;
  logic [DATA_W-1:0] wdata_q, wdata_sel;
  logic              we_q, we_sel;
  logic              aw_done_q, w_done_q;
  logic [15:0]       lat_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_resp_q;
  logic [15:0]       rsp_latency_q;
  logic              decode, busy;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int unsigned i = 0; i < 32'(N_REQ); i++) begin
      if (arb_grant[i]) begin
        addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = req_wdata[i*DATA_W +: DATA_W];
        we_sel    = req_we[i];
      end
    end
  end

  // Arbitration runs in DONE as well as IDLE so a grant lands the cycle after DONE;
  // the IDLE cycle carrying the req_ready pulse does not re-arbitrate.
  assign decode = (|req_valid) &&
                  (((state_q == ST_IDLE) && !(|req_ready_q)) || (state_q == ST_DONE));
  assign busy   = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bready  && m_axi_bvalid;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rready  && m_axi_rvalid;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req_ready_q) state_d = we_q ? ST_WR : ST_RD_ADDR;
      ST_WR:      if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_d = ST_DONE;
      ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
    m_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
    m_axi_bready  = (state_q == ST_WR_RESP);
    m_axi_arvalid = (state_q == ST_RD_ADDR);
    m_axi_rready  = (state_q == ST_RD_DATA);
    rsp_valid     = (state_q == ST_DONE) ? gnt_q : '0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      req_ready_q   <= '0;
      gnt_q         <= '0;
      rr_ptr_q      <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      lat_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_latency_q <= '0;
    end else begin
      req_ready_q <= decode ? arb_grant : '0;
      if (decode) begin
        addr_q   <= addr_sel;
        wdata_q  <= wdata_sel;
        we_q     <= we_sel;
        gnt_q    <= arb_grant;
        rr_ptr_q <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        lat_q    <= '0;
      end else if (busy) begin
        lat_q <= lat_inc(lat_q);
      end
      aw_done_q <= (state_q == ST_WR) && (aw_done_q || aw_hs);
      w_done_q  <= (state_q == ST_WR) && (w_done_q || w_hs);
      // Captured latency includes the handshake cycle itself.
      if (b_hs) begin
        rsp_rdata_q   <= '0;
        rsp_resp_q    <= m_axi_bresp;
        rsp_latency_q <= lat_inc(lat_q);
      end
      if (r_hs) begin
        rsp_rdata_q   <= m_axi_rdata;
        rsp_resp_q    <= m_axi_rresp;
        rsp_latency_q <= lat_inc(lat_q);
      end
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_latency  = rsp_latency_q;
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign m_axi_awprot = '0;
  assign m_axi_arprot = '0;
  assign m_axi_wstrb  = WSTRB_ALL;

endmodule
